// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the loader state encoding, the header/counter width, and the image
// checksum rule so the image tool, the loader and the bench agree on it.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int LOADER_LEN_W = 16;

  // Image checksum: length header plus the wrapped sum of all instruction
  // words, modulo 2^16. The header is deliberately part of the checksum.
  function automatic logic [LOADER_LEN_W-1:0] loader_checksum(
    input logic [LOADER_LEN_W-1:0] len,
    input logic [LOADER_LEN_W-1:0] sum
  );
    return len + sum;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader in front of instruction memory.
// Accepts a framed stream (length N, N words, checksum) over valid/ready,
// writes the words to LOAD_BASE.., and holds the CPU until the image checks.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   start              one-cycle pulse, re-arms the loader from DONE or ERR
//   in_valid/in_data   stream word in; in_ready (registered) accepts it
//   mem_we/addr/wdata  instruction memory write port, one cycle after the beat
//   cpu_hold           1 keeps the processor in reset
//   done / error       verified image resident / checksum mismatch (levels)
module prog_loader
  import loader_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 21,
  parameter int unsigned LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t                  state_q, state_d;
  logic [LOADER_LEN_W-1:0] len_q;
  logic [LOADER_LEN_W-1:0] cnt_q;
  logic [LOADER_LEN_W-1:0] cnt_inc;
  logic [DATA_W-1:0]       sum_q;
  logic                    accept;
  logic                    chk_ok;

  // States in which the loader consumes stream beats.
  function automatic logic is_busy(input state_t s);
    return s inside {HDR, LOAD, CHK};
  endfunction

  assign accept  = in_valid && in_ready;
  assign cnt_inc = cnt_q + 16'd1;
  assign chk_ok  = (in_data ==
                    DATA_W'(loader_checksum(len_q, LOADER_LEN_W'(sum_q))));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = HDR;
      HDR:  if (accept) state_d = (LOADER_LEN_W'(in_data) == '0) ? CHK : LOAD;
      LOAD: if (accept && (cnt_inc == len_q)) state_d = CHK;
      CHK:  if (accept) state_d = chk_ok ? DONE : ERR;
      DONE: if (start) state_d = HDR;
      ERR:  if (start) state_d = HDR;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> registered outputs: control state, handshake and write port.
  // in_ready needs both the current and next state busy, so it rises one
  // cycle after entering HDR and drops on the very edge that leaves CHK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= is_busy(state_q) && is_busy(state_d);
      mem_we   <= (state_q == LOAD) && accept;
      if ((state_q == LOAD) && accept) begin
        mem_addr  <= ADDR_W'(LOAD_BASE) + ADDR_W'(cnt_q);
        mem_wdata <= in_data;
      end
      cpu_hold <= (state_d != DONE);
      done     <= (state_d == DONE);
      error    <= (state_d == ERR);
    end
  end

  // Image bookkeeping; re-initialised by every header, so no reset needed.
  // Reset still blocks updates so a beat coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      case (state_q)
        HDR: begin
          len_q <= LOADER_LEN_W'(in_data);
          cnt_q <= '0;
          sum_q <= '0;
        end
        LOAD: begin
          cnt_q <= cnt_inc;
          sum_q <= sum_q + in_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected memory writes are queued as
// beats are driven and checked as the write port pulses.
module tb_prog_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 21;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int n_checks = 0;
  int n_err    = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_BASE(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pending_writes_at_we", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data", 32'(mem_wdata), 32'(e[DATA_W-1:0]));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [DATA_W-1:0] d, input bit is_data);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check(is_data ? "we_latency" : "we_quiet", 32'(mem_we), 32'(is_data));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [DATA_W-1:0] words[$], input logic [DATA_W-1:0] cks,
                      input int gap);
    send(DATA_W'(words.size()), 1'b0);
    for (int i = 0; i < words.size(); i++) begin
      if (gap > 0) idle(gap);
      exp_q.push_back({ADDR_W'(i), words[i]});
      send(words[i], 1'b1);
    end
    if (gap > 0) idle(gap);
    send(cks, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    idle(2);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;

    // Nominal three-word image.
    load('{16'h1111, 16'h2222, 16'h3333}, 16'h6669, 0);
    check("nom_done", 32'(done), 32'd1);
    check("nom_cpu_hold", 32'(cpu_hold), 32'd0);
    check("nom_error", 32'(error), 32'd0);
    check("nom_in_ready", 32'(in_ready), 32'd0);
    check("nom_writes_left", 32'(exp_q.size()), 32'd0);

    // Re-arm from DONE, then empty image.
    pulse_start();
    check("rearm_done_clr", 32'(done), 32'd0);
    check("rearm_hold_set", 32'(cpu_hold), 32'd1);
    load('{}, 16'h0000, 0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_cpu_hold", 32'(cpu_hold), 32'd0);

    // Bad checksum.
    pulse_start();
    load('{16'hAAAA, 16'h5555}, 16'h0000, 0);
    check("bad_error", 32'(error), 32'd1);
    check("bad_cpu_hold", 32'(cpu_hold), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_in_ready", 32'(in_ready), 32'd0);
    check("bad_writes_left", 32'(exp_q.size()), 32'd0);
    idle(3);
    check("bad_error_held", 32'(error), 32'd1);

    // Re-arm from ERR; wrapping sum with back-pressure gaps.
    pulse_start();
    check("err_clr", 32'(error), 32'd0);
    check("err_rearm_hold", 32'(cpu_hold), 32'd1);
    load('{16'hFFFF, 16'h0003}, 16'h0004, 5);
    check("wrap_done", 32'(done), 32'd1);
    check("wrap_error", 32'(error), 32'd0);
    check("wrap_writes_left", 32'(exp_q.size()), 32'd0);

    // Reset mid-load: reset coincides with the second data beat.
    pulse_start();
    send(16'd4, 1'b0);
    check("mid_cpu_hold", 32'(cpu_hold), 32'd1);
    exp_q.push_back({ADDR_W'(0), 16'h0101});
    send(16'h0101, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h0202;
    reset    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    check("midrst_we_dropped", 32'(mem_we), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    load('{16'h00AB}, 16'h00AC, 0);
    check("reload_done", 32'(done), 32'd1);
    check("reload_cpu_hold", 32'(cpu_hold), 32'd0);
    check("reload_writes_left", 32'(exp_q.size()), 32'd0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the pipeline's instruction memory. It accepts a framed stream of 16-bit words over a valid/ready handshake: a length header, N instruction words, and a checksum. It writes the words sequentially into instruction memory and holds the processor in reset until a checksum-verified image is resident. On success it releases the processor. On failure it keeps the processor held and flags an error.

## Interface
Parameters:
- DATA_W, 16, instruction/stream word width
- ADDR_W, 21, instruction memory address width
- LOAD_BASE, 0, first instruction memory address written

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; re-arms the loader from DONE or ERR
- in_valid  in  1  stream word present
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  instruction memory write address
- mem_wdata  out  DATA_W  instruction memory write data
- cpu_hold  out  1  1 keeps the processor in reset; 0 releases it
- done  out  1  image loaded and verified (level)
- error  out  1  checksum mismatch (level)

## Operation
- A beat is accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=0. Moves to HDR on the first cycle after reset, or on start.
  - HDR: in_ready=1. The accepted beat is the length header N. It is latched into len_q, and cnt, sum and the address pointer are cleared. If N==0, go to CHK; otherwise go to LOAD.
  - LOAD: in_ready=1. Each accepted beat is written to memory at address LOAD_BASE+cnt, is added into sum, and increments cnt. The beat that makes cnt==N moves the FSM to CHK.
  - CHK: in_ready=1. The accepted beat is compared with (N + sum) mod 2^16; the header word is included in the checksum. Match goes to DONE; mismatch goes to ERR.
  - DONE: in_ready=0, done=1, cpu_hold=0. On start, go to HDR, with cpu_hold=1 and done=0 from the next cycle.
  - ERR: in_ready=0, error=1, cpu_hold=1. On start, go to HDR and clear error.
- The start pulse is ignored in HDR, LOAD and CHK.
- Arithmetic rules:
  - sum is DATA_W bits and wraps silently.
  - cnt is 16 bits.
  - The address is LOAD_BASE + zero-extended cnt, truncated to ADDR_W.
- Back-pressure: the source may hold in_valid low for any number of cycles; the FSM waits in its current state with no side effects.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, state=IDLE.
- All outputs are registered.
- Memory write latency: a LOAD beat accepted in cycle t produces mem_we=1 in cycle t+1, with the matching mem_addr and mem_wdata. mem_we is a single-cycle pulse per beat.
- in_ready is registered. It rises the cycle after entry to HDR. It falls in the same cycle that the state register leaves CHK, so no beat is ever accepted in DONE or ERR.
- Verdict: a checksum beat accepted in cycle t gives done=1 and cpu_hold=0, or error=1, in cycle t+1.
- Throughput: one word per cycle with continuous in_valid. Full load time is N+2 accepted beats plus 1 cycle.
- Reset mid-operation: an asserted reset in any state returns to IDLE next cycle with all reset values. A write pending from the previous beat is dropped (mem_we=0). Memory contents are not cleared.
- Simultaneous events: reset has priority over start and any accepted beat.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum {IDLE, HDR, LOAD, CHK, DONE, ERR};
  - the LOADER_LEN_W=16 constant;
  - the checksum-function definition, so the assembler-side image tool and the bench use the same rule.
- No sub-module: the FSM, counter and accumulator form one flat module.
- At processor level, the processor reset is derived from reset and cpu_hold.

## Test plan
- Nominal load: stream 3, 0x1111, 0x2222, 0x3333, 0x6669.
  - Response: writes {0:0x1111, 1:0x2222, 2:0x3333}, each with mem_we one cycle after its beat; done=1 and cpu_hold=0 one cycle after the last beat.
- Empty image: stream 0, 0x0000.
  - Response: no mem_we pulse; done=1 one cycle after the checksum beat.
- Bad checksum: stream 2, 0xAAAA, 0x5555, 0x0000.
  - Response: both writes occur; error=1, cpu_hold stays 1, done=0, in_ready=0 afterwards.
- Wrap plus back-pressure: stream 2, 0xFFFF, 0x0003, 0x0004, with in_valid low for 5 cycles between each beat.
  - Response: writes at 0 and 1 only, with no extra writes during gaps; sum wraps; done=1.
- Reset mid-load: assert reset after the 2nd data beat of a 4-word image, then reload 1, 0x00AB, 0x00AC.
  - Response: cpu_hold=1 throughout; the reload writes address 0=0x00AB; done=1.
- Re-arm after error: pulse start in ERR, then stream a valid image.
  - Response: error clears the next cycle; the load completes with done=1.
